regfile_mp: RTL and testbench
=============================

# regfile_mp

Parametrised multi-read-port register file with registered reads, write/read collision reporting, a saturating collision counter and a hardware clear engine. It succeeds the fixed 32x16, two-read-port register file, and serves as the general operand store for datapath blocks needing 1-write / N-read access. On reset, and on request, the block scrubs its own storage instead of resetting the array in parallel.

## Interface
- `DATA_WIDTH`, 16: word width.
- `DEPTH`, 32: number of entries, ≥2; need not be a power of two.
- `NRD`, 2: number of read ports, ≥1.
- Derived localparam `AW = $clog2(DEPTH)`.

- `clk`  in  1  single clock, rising edge.
- `resetn`  in  1  synchronous, active-low reset.
- `din`  in  DATA_WIDTH  write data.
- `wad`  in  AW  write address.
- `wen`  in  1  write enable.
- `rad`  in  NRD*AW  packed read addresses; port i is `rad[i*AW +: AW]`.
- `ren`  in  NRD  per-port read enable.
- `clr`  in  1  start-clear request, one-cycle pulse.
- `dout`  out  NRD*DATA_WIDTH  packed registered read data.
- `rvalid`  out  NRD  per-port read-data-valid.
- `collision`  out  1  registered: a read/write address collision occurred last cycle.
- `coll_count`  out  16  saturating count of collision cycles.
- `busy`  out  1  clear engine active.

## Operation
- FSM states: `RF_CLEAR` and `RF_READY`.
  - Reset enters `RF_CLEAR` with clear pointer = 0.
  - In `RF_CLEAR`, one entry per cycle is written 0, at pointer 0..DEPTH-1.
  - After writing DEPTH-1, the FSM moves to `RF_READY`.
  - In `RF_READY`, `clr`=1 moves the FSM to `RF_CLEAR` with pointer 0.
- While in `RF_CLEAR`:
  - `wen`, `ren` and `clr` are ignored.
  - `rvalid` = 0, `dout` = 0, `collision` = 0.
  - `busy` = 1.
- In `RF_READY`, write: if `wen` and `wad` < DEPTH, then `mem[wad]` <= `din`. Writes with `wad` ≥ DEPTH are dropped silently.
- In `RF_READY`, read port i:
  - If `ren[i]`, then `rvalid[i]` <= 1 and `dout[i]` <= `mem[rad_i]`.
  - If `rad_i` ≥ DEPTH, the read returns 0.
  - If not `ren[i]`, then `rvalid[i]` <= 0 and `dout[i]` <= 0.
- Collision condition: any i with `wen & ren[i] & (rad_i == wad)` and `wad` < DEPTH.
  - Read/read address matches are never collisions; all read ports are independent.
  - On a collision, `collision` <= 1 and `coll_count` increments, saturating at 16'hFFFF.
  - The write still occurs; it is not blocked.
  - Data returned on the colliding port is set by the `RF_BYPASS_EN` macro (see Configuration).
- `clr` and `wen` in the same `RF_READY` cycle: `clr` wins and the write is dropped. Reads in that cycle are still serviced with the pre-clear contents.
- `coll_count` is cleared only by reset; `clr` does not clear it.

## Timing
- Reset values: `dout` = 0, `rvalid` = 0, `collision` = 0, `coll_count` = 0, `busy` = 1.
- The array itself is not reset; the clear engine scrubs it.
- Reset clear: the first DEPTH rising edges with `resetn`=1 clear entries 0..DEPTH-1.
  - `busy` falls after the DEPTH-th edge.
  - The first accepted access is on the following edge.
- `clr` sampled at edge t: `busy`=1 from t+1 for exactly DEPTH cycles.
- Read latency is 1 cycle: address at edge t, `dout`/`rvalid` valid after edge t.
- A write at edge t is visible to non-bypassed reads issued at edge t+1.
- `collision` is asserted for the one cycle after the colliding edge.
- `resetn` low during a clear aborts it and restarts from pointer 0 once released.

## Configuration
- Macro `RF_BYPASS_EN` defined: a colliding read port returns `din` (write-through forwarding).
- Macro `RF_BYPASS_EN` undefined: a colliding read port returns the old `mem[rad_i]` contents.
- `collision` and `coll_count` behave identically in both builds.

## Structure
- Package `regfile_pkg` holds:
  - `typedef enum logic {RF_CLEAR, RF_READY} rf_state_t`.
  - The counter width constant `RF_CNT_W = 16`.
- Sub-module `regfile_clear_ctrl` holds the FSM and clear pointer.
  - Inputs: `clk`, `resetn`, `clr`.
  - Outputs: `busy`, `clr_we`, `clr_addr`.
- The top level holds the array, the read ports (generate loop over NRD), and the collision logic and counter.

## Test plan
- Reset, then hold idle → `busy`=1 for 32 cycles then 0; all 32 entries read back 0 on both ports.
- Write 16'hA5A5 @5; next cycle read port 0 @5, port 1 @5 → both `dout`=16'hA5A5, `rvalid`=2'b11, `collision`=0.
- Write 16'h1234 @7 with the old value 16'h0F0F, reading @7 on port 1 in the same cycle → `collision`=1 next cycle and `coll_count`=1. Port 1 returns 16'h1234 with `RF_BYPASS_EN`, 16'h0F0F without; a later read returns 16'h1234.
- Pulse `clr` together with `wen`=1 @3 → the write is dropped; `busy` is high for 32 cycles; entry 3 and all other entries then read 0.
- Drive `DEPTH`=20, `NRD`=3: write @25, read @25 → `rvalid`=1 with `dout`=0 and no collision; reset asserted mid-clear → `busy` restarts with a full 20-cycle clear.
- Force 65 540 collision cycles → `coll_count` holds at 16'hFFFF.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types and constants for the multi-read-port register file.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package regfile_pkg;

   // Clear engine state: scrubbing the array, or open for accesses
   typedef enum logic {
      RF_CLEAR = 1'b0,
      RF_READY = 1'b1
   } rf_state_t;

   // Width and ceiling of the saturating collision counter
   localparam int                  RF_CNT_W   = 16;
   localparam logic [RF_CNT_W-1:0] RF_CNT_MAX = '1;

endpackage

// File: rtl/regfile_clear_ctrl.sv
// Clear engine: walks a pointer over every entry, zeroing one entry per cycle.
// Latency: DEPTH cycles per clear; a clear starts on the edge after reset release or a clr pulse.
// Backpressure: none; clr is ignored while a clear is already running.
module regfile_clear_ctrl
   import regfile_pkg::*;
#(
   parameter int   DEPTH = 32,
   localparam int  AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          resetn,
   input  logic          clr,
   output logic          busy,
   output logic          clr_we,
   output logic [AW-1:0] clr_addr
);

   localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

   rf_state_t     state_q;
   logic [AW-1:0] ptr_q;

   // Clear FSM: reset or clr restarts the scrub from entry 0; leaving CLEAR after the last entry
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q <= RF_CLEAR;
         ptr_q   <= '0;
      end else begin
         case (state_q)
            RF_CLEAR: begin
               if (ptr_q == LAST_ADDR) begin
                  state_q <= RF_READY;
                  ptr_q   <= '0;
               end else begin
                  ptr_q <= ptr_q + 1'b1;
               end
            end
            RF_READY: begin
               if (clr) begin
                  state_q <= RF_CLEAR;
                  ptr_q   <= '0;
               end
            end
            default: begin
               state_q <= RF_CLEAR;
               ptr_q   <= '0;
            end
         endcase
      end
   end

   // Outputs come straight off the state and pointer registers
   assign busy     = (state_q == RF_CLEAR);
   assign clr_we   = (state_q == RF_CLEAR);
   assign clr_addr = ptr_q;

endmodule

// File: rtl/regfile_mp.sv
// 1-write / NRD-read register file with collision reporting and a self-scrubbing clear engine.
// Latency: 1 cycle read (address at edge t, dout/rvalid after edge t); writes visible at t+1.
// Backpressure: none; accesses are dropped while busy. Build option RF_BYPASS_EN forwards din to colliding reads.
module regfile_mp
   import regfile_pkg::*;
#(
   parameter int   DATA_WIDTH = 16,
   parameter int   DEPTH      = 32,
   parameter int   NRD        = 2,
   localparam int  AW         = $clog2(DEPTH)
) (
   input  logic                       clk,
   input  logic                       resetn,
   input  logic [DATA_WIDTH-1:0]      din,
   input  logic [AW-1:0]              wad,
   input  logic                       wen,
   input  logic [NRD*AW-1:0]          rad,
   input  logic [NRD-1:0]             ren,
   input  logic                       clr,
   output logic [NRD*DATA_WIDTH-1:0]  dout,
   output logic [NRD-1:0]             rvalid,
   output logic                       collision,
   output logic [RF_CNT_W-1:0]        coll_count,
   output logic                       busy
);

   // One extra bit so a non-power-of-two DEPTH can be range-checked against the address
   localparam logic [AW:0] DEPTH_EXT = (AW + 1)'(DEPTH);

   logic                  busy_w;
   logic                  clr_we;
   logic [AW-1:0]         clr_addr;
   logic                  ready;
   logic                  wad_ok;
   logic                  wr_fire;
   logic [NRD-1:0]        hit;
   logic                  coll_d;
   logic                  collision_q;
   logic [RF_CNT_W-1:0]   coll_count_q;
   logic [RF_CNT_W-1:0]   coll_count_d;

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   regfile_clear_ctrl #(
      .DEPTH (DEPTH)
   ) u_clear_ctrl (
      .clk      (clk),
      .resetn   (resetn),
      .clr      (clr),
      .busy     (busy_w),
      .clr_we   (clr_we),
      .clr_addr (clr_addr)
   );

   assign ready  = ~busy_w;
   assign wad_ok = ({1'b0, wad} < DEPTH_EXT);
   // A clr in the same cycle wins over the write
   assign wr_fire = ready & wen & ~clr & wad_ok;

   // Array write: the scrub owns the write port while the clear engine runs
   always_ff @(posedge clk) begin
      if (clr_we) begin
         mem[clr_addr] <= '0;
      end else if (wr_fire) begin
         mem[wad] <= din;
      end
   end

   genvar gi;
   for (gi = 0; gi < NRD; gi++) begin : g_rd
      logic [AW-1:0]         rad_i;
      logic                  rad_ok;
      logic [DATA_WIDTH-1:0] rdata_d;
      logic [DATA_WIDTH-1:0] dout_q;
      logic                  rvalid_q;

      assign rad_i  = rad[gi*AW +: AW];
      assign rad_ok = ({1'b0, rad_i} < DEPTH_EXT);
      // Read/write address match on this port; read/read matches are irrelevant
      assign hit[gi] = ready & wen & wad_ok & ren[gi] & (rad_i == wad);

      // Read data select: out-of-range reads return 0; optional write-through on a collision
      always_comb begin
         rdata_d = '0;
         if (rad_ok) begin
            rdata_d = mem[rad_i];
         end
`ifdef RF_BYPASS_EN
         // Forward only when the write really lands (a concurrent clr drops it)
         if (hit[gi] & ~clr) begin
            rdata_d = din;
         end
`endif
      end

      // Registered read port: data and valid are cleared whenever no read is serviced
      always_ff @(posedge clk) begin
         if (!resetn) begin
            dout_q   <= '0;
            rvalid_q <= 1'b0;
         end else if (ready & ren[gi]) begin
            dout_q   <= rdata_d;
            rvalid_q <= 1'b1;
         end else begin
            dout_q   <= '0;
            rvalid_q <= 1'b0;
         end
      end

      assign dout[gi*DATA_WIDTH +: DATA_WIDTH] = dout_q;
      assign rvalid[gi]                        = rvalid_q;
   end

   assign coll_d = |hit;

   // Saturating collision counter next value; only reset clears it
   always_comb begin
      coll_count_d = coll_count_q;
      if (coll_d && (coll_count_q != RF_CNT_MAX)) begin
         coll_count_d = coll_count_q + 1'b1;
      end
   end

   // Collision flag and counter registers
   always_ff @(posedge clk) begin
      if (!resetn) begin
         collision_q  <= 1'b0;
         coll_count_q <= '0;
      end else begin
         collision_q  <= coll_d;
         coll_count_q <= coll_count_d;
      end
   end

   assign collision  = collision_q;
   assign coll_count = coll_count_q;
   assign busy       = busy_w;

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: default 32x16 two-port instance plus a 20-entry three-port instance.
// Expected values are hand-computed; bypass-dependent values follow the RF_BYPASS_EN build option.
module tb_regfile_mp;

`ifdef RF_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // Default instance: DEPTH 32, NRD 2
   logic        resetn;
   logic [15:0] din;
   logic [4:0]  wad;
   logic        wen;
   logic [9:0]  rad;
   logic [1:0]  ren;
   logic        clr;
   logic [31:0] dout;
   logic [1:0]  rvalid;
   logic        collision;
   logic [15:0] coll_count;
   logic        busy;

   // Second instance: DEPTH 20, NRD 3
   logic        r20_resetn;
   logic [15:0] r20_din;
   logic [4:0]  r20_wad;
   logic        r20_wen;
   logic [14:0] r20_rad;
   logic [2:0]  r20_ren;
   logic        r20_clr;
   logic [47:0] r20_dout;
   logic [2:0]  r20_rvalid;
   logic        r20_collision;
   logic [15:0] r20_coll_count;
   logic        r20_busy;

   regfile_mp #(.DATA_WIDTH(16), .DEPTH(32), .NRD(2)) dut (
      .clk        (clk),
      .resetn     (resetn),
      .din        (din),
      .wad        (wad),
      .wen        (wen),
      .rad        (rad),
      .ren        (ren),
      .clr        (clr),
      .dout       (dout),
      .rvalid     (rvalid),
      .collision  (collision),
      .coll_count (coll_count),
      .busy       (busy)
   );

   regfile_mp #(.DATA_WIDTH(16), .DEPTH(20), .NRD(3)) dut20 (
      .clk        (clk),
      .resetn     (r20_resetn),
      .din        (r20_din),
      .wad        (r20_wad),
      .wen        (r20_wen),
      .rad        (r20_rad),
      .ren        (r20_ren),
      .clr        (r20_clr),
      .dout       (r20_dout),
      .rvalid     (r20_rvalid),
      .collision  (r20_collision),
      .coll_count (r20_coll_count),
      .busy       (r20_busy)
   );

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic        wen;
      logic [4:0]  wad;
      logic [15:0] din;
      logic [1:0]  ren;
      logic [4:0]  rad0;
      logic [4:0]  rad1;
      logic [15:0] e0;
      logic [15:0] e1;
      logic [1:0]  ev;
      logic        ecoll;
      logic [15:0] ecnt;
   } vec_t;

   vec_t tv[11];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int n;
      bit bad;

      // Stimulus table: each row is one clock edge; expectations are the outputs after that edge
      tv[0]  = '{1'b1, 5'd5,  16'hA5A5, 2'b00, 5'd0,  5'd0,  16'h0000, 16'h0000, 2'b00, 1'b0, 16'd0};
      tv[1]  = '{1'b0, 5'd0,  16'h0000, 2'b11, 5'd5,  5'd5,  16'hA5A5, 16'hA5A5, 2'b11, 1'b0, 16'd0};
      tv[2]  = '{1'b1, 5'd7,  16'h0F0F, 2'b01, 5'd5,  5'd0,  16'hA5A5, 16'h0000, 2'b01, 1'b0, 16'd0};
      tv[3]  = '{1'b1, 5'd7,  16'h1234, 2'b10, 5'd0,  5'd7,  16'h0000, BYP ? 16'h1234 : 16'h0F0F, 2'b10, 1'b1, 16'd1};
      tv[4]  = '{1'b0, 5'd0,  16'h0000, 2'b11, 5'd7,  5'd5,  16'h1234, 16'hA5A5, 2'b11, 1'b0, 16'd1};
      tv[5]  = '{1'b1, 5'd10, 16'hBEEF, 2'b11, 5'd5,  5'd5,  16'hA5A5, 16'hA5A5, 2'b11, 1'b0, 16'd1};
      tv[6]  = '{1'b1, 5'd10, 16'hCAFE, 2'b01, 5'd10, 5'd0,  BYP ? 16'hCAFE : 16'hBEEF, 16'h0000, 2'b01, 1'b1, 16'd2};
      tv[7]  = '{1'b1, 5'd3,  16'h1111, 2'b00, 5'd3,  5'd3,  16'h0000, 16'h0000, 2'b00, 1'b0, 16'd2};
      tv[8]  = '{1'b0, 5'd0,  16'h0000, 2'b11, 5'd3,  5'd10, 16'h1111, 16'hCAFE, 2'b11, 1'b0, 16'd2};
      tv[9]  = '{1'b1, 5'd3,  16'h2222, 2'b11, 5'd3,  5'd3,  BYP ? 16'h2222 : 16'h1111, BYP ? 16'h2222 : 16'h1111, 2'b11, 1'b1, 16'd3};
      tv[10] = '{1'b0, 5'd0,  16'h0000, 2'b11, 5'd3,  5'd7,  16'h2222, 16'h1234, 2'b11, 1'b0, 16'd3};

      resetn = 1'b0; din = '0; wad = '0; wen = 1'b0; rad = '0; ren = '0; clr = 1'b0;
      r20_resetn = 1'b0; r20_din = '0; r20_wad = '0; r20_wen = 1'b0; r20_rad = '0; r20_ren = '0; r20_clr = 1'b0;
      repeat (3) step();

      chk("reset busy", busy, 1'b1);
      chk("reset rvalid", rvalid, 2'b00);
      chk("reset dout", dout, 32'h0);
      chk("reset collision", collision, 1'b0);
      chk("reset coll_count", coll_count, 16'h0);

      // Reset clear: accesses driven throughout must be ignored
      resetn = 1'b1;
      wen = 1'b1; wad = 5'd9; din = 16'hFFFF; ren = 2'b11; rad = {5'd9, 5'd9};
      n = 0; bad = 1'b0;
      for (int c = 0; c < 200; c++) begin
         step();
         n++;
         if (rvalid != 2'b00 || dout != 32'h0 || collision) bad = 1'b1;
         if (!busy) break;
      end
      chk("reset clear edges", n, 32);
      chk("outputs idle during reset clear", bad, 1'b0);
      wen = 1'b0; ren = 2'b00;

      for (int a = 0; a < 32; a++) begin
         ren = 2'b11; rad = {5'(31 - a), 5'(a)};
         step();
         chk($sformatf("post-reset read %0d", a), {rvalid, dout}, {2'b11, 32'h0});
      end

      for (int k = 0; k < 11; k++) begin
         wen = tv[k].wen; wad = tv[k].wad; din = tv[k].din;
         ren = tv[k].ren; rad = {tv[k].rad1, tv[k].rad0};
         step();
         chk($sformatf("vec%0d dout0", k), dout[15:0], tv[k].e0);
         chk($sformatf("vec%0d dout1", k), dout[31:16], tv[k].e1);
         chk($sformatf("vec%0d rvalid", k), rvalid, tv[k].ev);
         chk($sformatf("vec%0d collision", k), collision, tv[k].ecoll);
         chk($sformatf("vec%0d coll_count", k), coll_count, tv[k].ecnt);
      end
      wen = 1'b0; ren = 2'b00;

      // clr together with a write: write dropped, reads in that cycle see pre-clear data
      clr = 1'b1; wen = 1'b1; wad = 5'd3; din = 16'h7777; ren = 2'b11; rad = {5'd7, 5'd5};
      step();
      clr = 1'b0; wen = 1'b0;
      chk("clr-cycle dout", dout, {16'h1234, 16'hA5A5});
      chk("clr-cycle rvalid", rvalid, 2'b11);
      chk("clr-cycle busy", busy, 1'b1);
      chk("clr-cycle collision", collision, 1'b0);
      rad = {5'd3, 5'd3};
      n = 1; bad = 1'b0;
      for (int c = 0; c < 200; c++) begin
         step();
         if (rvalid != 2'b00 || dout != 32'h0) bad = 1'b1;
         if (!busy) break;
         n++;
      end
      chk("clr busy cycles", n, 32);
      chk("outputs idle during clr", bad, 1'b0);
      for (int a = 0; a < 32; a++) begin
         ren = 2'b11; rad = {5'(31 - a), 5'(a)};
         step();
         chk($sformatf("post-clr read %0d", a), {rvalid, dout}, {2'b11, 32'h0});
      end
      ren = 2'b00;
      step();
      chk("coll_count survives clr", coll_count, 16'd3);

      // DEPTH 20 / NRD 3: reset mid-clear restarts a full clear
      r20_resetn = 1'b1;
      repeat (5) step();
      chk("d20 busy mid-clear", r20_busy, 1'b1);
      r20_resetn = 1'b0;
      step();
      chk("d20 busy in reset", r20_busy, 1'b1);
      chk("d20 rvalid in reset", r20_rvalid, 3'b000);
      r20_resetn = 1'b1;
      r20_ren = 3'b111; r20_rad = {5'd1, 5'd2, 5'd3};
      n = 0; bad = 1'b0;
      for (int c = 0; c < 200; c++) begin
         step();
         n++;
         if (r20_rvalid != 3'b000) bad = 1'b1;
         if (!r20_busy) break;
      end
      chk("d20 restarted clear edges", n, 20);
      chk("d20 rvalid idle during clear", bad, 1'b0);

      r20_wen = 1'b1; r20_wad = 5'd25; r20_din = 16'hFFFF; r20_ren = 3'b100; r20_rad = {5'd25, 5'd0, 5'd0};
      step();
      chk("d20 oob write+read", {r20_rvalid, r20_dout}, {3'b100, 48'h0});
      chk("d20 oob no collision", r20_collision, 1'b0);
      r20_wen = 1'b1; r20_wad = 5'd19; r20_din = 16'h1357; r20_ren = 3'b111; r20_rad = {5'd25, 5'd25, 5'd25};
      step();
      chk("d20 oob read all ports", {r20_rvalid, r20_dout}, {3'b111, 48'h0});
      chk("d20 oob read no collision", r20_collision, 1'b0);
      r20_wen = 1'b0; r20_ren = 3'b011; r20_rad = {5'd0, 5'd25, 5'd19};
      step();
      chk("d20 last entry read", {r20_rvalid, r20_dout}, {3'b011, 16'h0, 16'h0, 16'h1357});
      chk("d20 coll_count", r20_coll_count, 16'h0);
      r20_ren = 3'b000;

      // Saturation: continuous collisions on port 0 from a count of 3
      wen = 1'b1; wad = 5'd0; din = 16'h0; ren = 2'b01; rad = {5'd0, 5'd0};
      repeat (65531) step();
      chk("coll_count near max", coll_count, 16'hFFFE);
      chk("collision during run", collision, 1'b1);
      repeat (9) step();
      chk("coll_count saturated", coll_count, 16'hFFFF);
      wen = 1'b0; ren = 2'b00;
      step();
      chk("collision drops", collision, 1'b0);
      chk("coll_count holds", coll_count, 16'hFFFF);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
